// File: rtl/barrel_pkg.sv
// rtl/barrel_pkg.sv - shared mode encoding and default width for the right barrel shifter
package barrel_pkg;

    typedef enum logic [1:0] {
        SH_LOGIC = 2'b00,
        SH_ROT   = 2'b01,
        SH_ARITH = 2'b10
    } shift_mode_e;

    localparam int BARREL_W = 8;

endpackage

// File: rtl/barrel_shift_stage.sv
// rtl/barrel_shift_stage.sv - one pipeline stage: conditional right shift/rotate by STEP
// Sign-carry register only exists when BARREL_SHIFTER_RIGHT_ARITH_EN is defined.
module barrel_shift_stage
    import barrel_pkg::*;
#(
    parameter int W    = BARREL_W,
    parameter int STEP = 1,
    parameter int SHW  = $clog2(W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           prev_valid,
    input  logic [W-1:0]   prev_data,
    input  logic [SHW-1:0] prev_amt,
    input  logic [1:0]     prev_mode,
`ifdef BARREL_SHIFTER_RIGHT_ARITH_EN
    input  logic           prev_sign,
    output logic           sign,
`endif
    input  logic           adv_next,
    output logic           adv,
    output logic           valid,
    output logic [W-1:0]   data,
    output logic [SHW-1:0] amt,
    output logic [1:0]     mode
);

    localparam int BIT = $clog2(STEP);

    logic [W-1:0] shifted;

    // Load when empty or when the current word moves on this same edge.
    assign adv = !valid || adv_next;

    always_comb begin
        shifted = prev_data;
        if (prev_amt[BIT]) begin
            if (prev_mode == SH_ROT)
                shifted = {prev_data[STEP-1:0], prev_data[W-1:STEP]};
`ifdef BARREL_SHIFTER_RIGHT_ARITH_EN
            else if (prev_mode == SH_ARITH)
                shifted = (prev_data >> STEP) | (prev_sign ? ~({W{1'b1}} >> STEP) : '0);
`endif
            else
                shifted = prev_data >> STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            amt   <= '0;
            mode  <= '0;
`ifdef BARREL_SHIFTER_RIGHT_ARITH_EN
            sign  <= 1'b0;
`endif
        end else if (adv) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data <= shifted;
                amt  <= prev_amt;
                mode <= prev_mode;
`ifdef BARREL_SHIFTER_RIGHT_ARITH_EN
                sign <= prev_sign;
`endif
            end
        end
    end

endmodule

// File: rtl/barrel_shifter_right_pipe.sv
// rtl/barrel_shifter_right_pipe.sv - pipelined right shifter/rotator, one stage per amount bit
// Optional arithmetic mode via BARREL_SHIFTER_RIGHT_ARITH_EN.
module barrel_shifter_right_pipe
    import barrel_pkg::*;
#(
    parameter int W = BARREL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic [$clog2(W)-1:0] in_amt,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data
);

    localparam int SHW = $clog2(W);

    // Index 0 is the input side, index SHW is the output register of the last stage.
    logic [SHW:0]            vld_c;
    logic [SHW:0]            adv_c;
    logic [SHW:0][W-1:0]     dat_c;
    logic [SHW:0][SHW-1:0]   amt_c;
    logic [SHW:0][1:0]       mode_c;
`ifdef BARREL_SHIFTER_RIGHT_ARITH_EN
    logic [SHW:0]            sign_c;
    assign sign_c[0] = in_data[W-1];
`endif

    assign vld_c[0]    = in_valid;
    assign dat_c[0]    = in_data;
    assign amt_c[0]    = in_amt;
    assign mode_c[0]   = in_mode;
    assign adv_c[SHW]  = out_ready;
    assign in_ready    = adv_c[0];
    assign out_valid   = vld_c[SHW];
    assign out_data    = dat_c[SHW];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        barrel_shift_stage #(
            .W    (W),
            .STEP (2 ** k),
            .SHW  (SHW)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .prev_valid (vld_c[k]),
            .prev_data  (dat_c[k]),
            .prev_amt   (amt_c[k]),
            .prev_mode  (mode_c[k]),
`ifdef BARREL_SHIFTER_RIGHT_ARITH_EN
            .prev_sign  (sign_c[k]),
            .sign       (sign_c[k+1]),
`endif
            .adv_next   (adv_c[k+1]),
            .adv        (adv_c[k]),
            .valid      (vld_c[k+1]),
            .data       (dat_c[k+1]),
            .amt        (amt_c[k+1]),
            .mode       (mode_c[k+1])
        );
    end

    // Side-band fields of the last stage have no consumer.
    logic unused_tail;
`ifdef BARREL_SHIFTER_RIGHT_ARITH_EN
    assign unused_tail = ^{amt_c[SHW], mode_c[SHW], sign_c[SHW]};
`else
    assign unused_tail = ^{amt_c[SHW], mode_c[SHW]};
`endif

endmodule

// File: tb/tb_barrel_shifter_right_pipe.sv
// tb/tb_barrel_shifter_right_pipe.sv - self-checking bench for barrel_shifter_right_pipe
module tb_barrel_shifter_right_pipe;

    localparam int W = 8;
`ifdef BARREL_SHIFTER_RIGHT_ARITH_EN
    localparam bit ARITH = 1'b1;
`else
    localparam bit ARITH = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = '0;
    logic [2:0]   in_amt = '0;
    logic [1:0]   in_mode = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_data;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    int cyc = 0;
    int first_out_cyc = -1;
    int last_out_cyc = -1;
    logic [7:0] sb[$];
    logic       held_valid = 1'b0;
    logic [7:0] held_data = '0;

    barrel_shifter_right_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(logic [7:0] d, int a, logic [1:0] m);
        logic [7:0] r;
        logic fill;
        fill = (ARITH && m == 2'b10) ? d[7] : 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i + a < W)       r[i] = d[i+a];
            else if (m == 2'b01) r[i] = d[i+a-W];
            else                 r[i] = fill;
        end
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: capture accepted inputs, check every delivered result and stall stability.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            held_valid = 1'b0;
        end else begin
            if (held_valid && out_valid)
                chk("stall_stable", {24'd0, out_data}, {24'd0, held_data});
            if (out_valid && out_ready) begin
                n_out++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                if (sb.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
                else chk("sb_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
            end
            held_valid = out_valid && !out_ready;
            held_data  = out_data;
            if (in_valid && in_ready)
                sb.push_back(model(in_data, int'(in_amt), in_mode));
        end
    end

    task automatic directed(string name, logic [7:0] d, logic [2:0] a, logic [1:0] m, logic [7:0] exp);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m;
        @(negedge clk);
        chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = $urandom; in_amt = $urandom; in_mode = $urandom;
        repeat (2) begin
            @(negedge clk);
            chk({name, "_early"}, {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk);
        chk(name, {23'd0, out_valid, out_data}, {23'd0, 1'b1, exp});
    endtask

    initial begin
        int acc;
        int idx;
        logic [7:0] snap;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_state", {22'd0, out_valid, in_ready, out_data}, {22'd0, 1'b0, 1'b1, 8'h00});

        out_ready = 1'b1;
        directed("log_a4", 8'b1000_0000, 3'd4, 2'b00, 8'b0000_1000);
        directed("log_a7", 8'b1000_0000, 3'd7, 2'b00, 8'b0000_0001);
        directed("log_a0", 8'b1000_0000, 3'd0, 2'b00, 8'b1000_0000);
        directed("rot_a1", 8'b0000_0001, 3'd1, 2'b01, 8'b1000_0000);
        directed("rot_a3", 8'b1011_0001, 3'd3, 2'b01, 8'b0011_0110);
        directed("rot_a0", 8'b1011_0001, 3'd0, 2'b01, 8'b1011_0001);
        directed("ari_neg", 8'b1000_0000, 3'd2, 2'b10, ARITH ? 8'b1110_0000 : 8'b0010_0000);
        directed("ari_pos", 8'b0100_0000, 3'd2, 2'b10, 8'b0001_0000);
        directed("rsv_a1", 8'b1000_0000, 3'd1, 2'b11, 8'b0100_0000);

        // Backpressure: five offered words, pipe holds three.
        @(posedge clk); #1;
        out_ready = 1'b0;
        acc = 0;
        idx = 0;
        in_valid = 1'b1; in_data = 8'hA5; in_amt = 3'd1; in_mode = 2'b01;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
            if (in_ready || acc > idx) begin
                idx = acc;
                in_data = $urandom; in_amt = $urandom; in_mode = $urandom;
            end
        end
        @(negedge clk);
        chk("bp_accepted", acc, 3);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        snap = out_data;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, snap});
        @(posedge clk); #1;
        out_ready = 1'b1;
        n_out = 0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_drain_valid", {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        chk("bp_drain_done", {n_out, 31'd0, out_valid}, {32'd3, 32'd0});

        // Throughput: 20 back-to-back random words.
        @(posedge clk); #1;
        n_out = 0;
        first_out_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1; in_data = $urandom; in_amt = $urandom; in_mode = $urandom;
            @(negedge clk);
            chk("tp_in_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("tp_count", n_out, 20);
        chk("tp_span", last_out_cyc - first_out_cyc, 19);
        chk("tp_sb_empty", sb.size(), 0);

        // Reset with two words in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hFF; in_amt = 3'd0; in_mode = 2'b00;
        @(posedge clk); #1;
        in_data = 8'h7E;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid", {22'd0, out_valid, in_ready, out_data}, {22'd0, 1'b0, 1'b1, 8'h00});
        out_ready = 1'b1;
        n_out = 0;
        repeat (8) @(negedge clk);
        chk("rst_no_stale", n_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
